// File: rtl/param_transmitter_pkg.sv
// Shared types, parity modes and parameter-legality helpers for the serial transmitter.
package param_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    function automatic bit params_legal(input int unsigned data_size,
                                        input int unsigned clks_per_bit,
                                        input int unsigned parity,
                                        input int unsigned stop_bits);
        return (data_size >= 5) && (data_size <= 9) && (clks_per_bit >= 1) &&
               (parity <= PARITY_ODD) && ((stop_bits == 1) || (stop_bits == 2));
    endfunction

    // Counter width that still works for a modulus of 1.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/param_transmitter_if.sv
// Parallel-word handshake between a word producer (master) and the transmitter (slave).
interface param_transmitter_if #(
    parameter int unsigned DATA_SIZE = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/param_transmitter_baud_tick.sv
// Bit-period timer: tick is high in the last cycle of every CLKS_PER_BIT-cycle bit.
module baud_tick
    import param_transmitter_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic bclk,
    input  logic rst_n,
    input  logic restart,
    output logic tick,
    output logic tick_nxt_c
);
    localparam int unsigned   CW       = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic          RST_TICK = (LAST == '0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Wrap at the end of each bit; held at zero while restart is asserted.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= RST_TICK;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick       = tick_q;
    assign tick_nxt_c = tick_d;

endmodule

// File: rtl/param_transmitter.sv
// Parameterised serial transmitter with a one-word holding buffer and registered line outputs.
module param_transmitter
    import param_transmitter_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                bclk,
    input  logic                rst_n,
    param_transmitter_if.slave  in_if,
    output logic                tx_data,
    output logic                tx_busy,
    output logic                tx_done
);
    localparam int unsigned    BCW       = $clog2(DATA_SIZE + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_SIZE - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
    localparam logic           ODD_FLIP  = (PARITY == PARITY_ODD);

    if (!params_legal(DATA_SIZE, CLKS_PER_BIT, PARITY, STOP_BITS)) begin : g_illegal_params
        $error("param_transmitter: illegal parameter combination");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic [DATA_SIZE-1:0] buf_q, buf_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 buf_full_q, buf_full_d;
    logic                 par_q, par_d;
    logic                 tx_data_q, tx_data_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 in_ready_q, in_ready_d;
    logic                 tick, tick_nxt, restart, accept, load;

    assign restart = (state_q == ST_IDLE);
    assign accept  = in_if.in_valid && in_ready_q;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .bclk       (bclk),
        .rst_n      (rst_n),
        .restart    (restart),
        .tick       (tick),
        .tick_nxt_c (tick_nxt)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        bit_cnt_d  = bit_cnt_q;
        buf_full_d = buf_full_q;
        par_d      = par_q;
        load       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (buf_full_q) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START: begin
                // Parity from the latched copy before any shifting.
                par_d = (^shift_q) ^ ODD_FLIP;
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        if (buf_full_q) begin
                            state_d = ST_START;
                            load    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // load and accept are exclusive: load needs a full buffer, accept an empty one.
        if (load) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
        end
        if (accept) begin
            buf_d      = in_if.in_data;
            buf_full_d = 1'b1;
        end

        in_ready_d = !buf_full_d;
        tx_busy_d  = (state_d != ST_IDLE);
        tx_done_d  = (state_d == ST_STOP) && (bit_cnt_d == LAST_STOP) && tick_nxt;

        unique case (state_d)
            ST_START:  tx_data_d = 1'b0;
            ST_DATA:   tx_data_d = shift_d[0];
            ST_PARITY: tx_data_d = par_d;
            default:   tx_data_d = 1'b1;
        endcase
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            buf_q      <= '0;
            bit_cnt_q  <= '0;
            buf_full_q <= 1'b0;
            par_q      <= 1'b0;
            tx_data_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            bit_cnt_q  <= bit_cnt_d;
            buf_full_q <= buf_full_d;
            par_q      <= par_d;
            tx_data_q  <= tx_data_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign tx_data        = tx_data_q;
    assign tx_busy        = tx_busy_q;
    assign tx_done        = tx_done_q;

endmodule

// File: tb/tb_param_transmitter.sv
// Scoreboard bench for param_transmitter: four parameter sets sharing one clock and reset.
module tb_param_transmitter;

    logic       bclk = 1'b0;
    logic       rst_n;
    logic       valid_r  [4];
    logic [7:0] data_r   [4];
    logic       tx_w     [4];
    logic       busy_w   [4];
    logic       done_w   [4];
    logic       ready_w  [4];

    int         checks   = 0;
    int         failures = 0;

    // Per-cycle {tx_data, tx_busy, tx_done}: expected pushed with stimulus, observed by capture.
    logic [2:0] exp_v[$];
    logic [2:0] obs_v[$];

    always #5 bclk = ~bclk;

    param_transmitter_if #(.DATA_SIZE(8)) if0 ();
    param_transmitter_if #(.DATA_SIZE(8)) if1 ();
    param_transmitter_if #(.DATA_SIZE(8)) if2 ();
    param_transmitter_if #(.DATA_SIZE(8)) if3 ();

    assign if0.in_valid = valid_r[0];
    assign if0.in_data  = data_r[0];
    assign ready_w[0]   = if0.in_ready;
    assign if1.in_valid = valid_r[1];
    assign if1.in_data  = data_r[1];
    assign ready_w[1]   = if1.in_ready;
    assign if2.in_valid = valid_r[2];
    assign if2.in_data  = data_r[2];
    assign ready_w[2]   = if2.in_ready;
    assign if3.in_valid = valid_r[3];
    assign if3.in_data  = data_r[3];
    assign ready_w[3]   = if3.in_ready;

    param_transmitter #(.DATA_SIZE(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .bclk(bclk), .rst_n(rst_n), .in_if(if0),
        .tx_data(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    param_transmitter #(.DATA_SIZE(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .bclk(bclk), .rst_n(rst_n), .in_if(if1),
        .tx_data(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    param_transmitter #(.DATA_SIZE(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .bclk(bclk), .rst_n(rst_n), .in_if(if2),
        .tx_data(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    param_transmitter #(.DATA_SIZE(8), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .bclk(bclk), .rst_n(rst_n), .in_if(if3),
        .tx_data(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    task automatic push_frame(input logic [7:0] w, input int par, input int stops, input int cpb);
        logic pb;
        for (int k = 0; k < cpb; k++) exp_v.push_back(3'b010);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < cpb; k++) exp_v.push_back({w[b], 2'b10});
        if (par != 0) begin
            pb = (par == 1) ? (^w) : ~(^w);
            for (int k = 0; k < cpb; k++) exp_v.push_back({pb, 2'b10});
        end
        for (int k = 0; k < stops * cpb; k++)
            exp_v.push_back({2'b11, (k == stops * cpb - 1)});
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) exp_v.push_back(3'b100);
    endtask

    task automatic capture(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge bclk);
            obs_v.push_back({tx_w[d], busy_w[d], done_w[d]});
        end
    endtask

    // Present one word on DUT d at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input int d, input logic [7:0] w);
        valid_r[d] = 1'b1;
        data_r[d]  = w;
        @(posedge bclk);
        @(negedge bclk);
        valid_r[d] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if ({tx_w[d], busy_w[d], done_w[d], ready_w[d]} !== 4'b1001) begin
                failures++;
                $display("FAIL reset_state dut%0d got tx/busy/done/ready=%b exp=1001", d,
                         {tx_w[d], busy_w[d], done_w[d], ready_w[d]});
            end
        end
        repeat (2) @(negedge bclk);
        rst_n = 1'b1;
        @(negedge bclk);
    endtask

    task automatic test_defaults;
        int n;
        logic [2:0] e, o;
        send_word(0, 8'hA5);
        checks++;
        if ({tx_w[0], busy_w[0], ready_w[0]} !== 3'b100) begin
            failures++;
            $display("FAIL defaults_accept got tx/busy/ready=%b exp=100",
                     {tx_w[0], busy_w[0], ready_w[0]});
        end
        push_frame(8'hA5, 0, 1, 4);
        push_idle(1);
        n = exp_v.size();
        capture(0, n);
        for (int i = 0; i < n; i++) begin
            e = exp_v.pop_front(); o = obs_v.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL defaults_a5 cycle %0d got tx/busy/done=%b exp=%b", i, o, e);
            end
        end
    endtask

    task automatic test_parity;
        int n;
        logic [2:0] e, o;
        for (int d = 1; d <= 2; d++) begin
            send_word(d, 8'h07);
            push_frame(8'h07, d, 1, 4);
            push_idle(1);
            n = exp_v.size();
            capture(d, n);
            for (int i = 0; i < n; i++) begin
                e = exp_v.pop_front(); o = obs_v.pop_front(); checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL parity_mode%0d cycle %0d got tx/busy/done=%b exp=%b", d, i, o, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [2:0] e, o;
        valid_r[0] = 1'b1;
        data_r[0]  = 8'h55;
        @(posedge bclk);
        @(negedge bclk);
        data_r[0] = 8'hAA;
        push_frame(8'h55, 0, 1, 4);
        push_frame(8'hAA, 0, 1, 4);
        push_idle(1);
        n = exp_v.size();
        fork
            capture(0, n);
            begin
                @(negedge bclk);
                checks++;
                if (ready_w[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready_free got %b exp 1", ready_w[0]);
                end
                @(posedge bclk);
                @(negedge bclk);
                valid_r[0] = 1'b0;
                for (int i = 0; i < 39; i++) begin
                    checks++;
                    if (ready_w[0] !== 1'b0) begin
                        failures++;
                        $display("FAIL b2b_ready_held step %0d got %b exp 0", i, ready_w[0]);
                    end
                    @(negedge bclk);
                end
                checks++;
                if (ready_w[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready_drain got %b exp 1", ready_w[0]);
                end
            end
        join
        for (int i = 0; i < n; i++) begin
            e = exp_v.pop_front(); o = obs_v.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_55_aa cycle %0d got tx/busy/done=%b exp=%b", i, o, e);
            end
        end
    endtask

    task automatic test_stop2_fast;
        int n;
        logic [2:0] e, o;
        send_word(3, 8'h00);
        push_frame(8'h00, 0, 2, 1);
        push_idle(2);
        n = exp_v.size();
        capture(3, n);
        for (int i = 0; i < n; i++) begin
            e = exp_v.pop_front(); o = obs_v.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stop2_cpb1 cycle %0d got tx/busy/done=%b exp=%b", i, o, e);
            end
        end
    endtask

    task automatic test_data_change;
        int n;
        logic [2:0] e, o;
        send_word(0, 8'h5C);
        push_frame(8'h5C, 0, 1, 4);
        push_idle(1);
        n = exp_v.size();
        fork
            capture(0, n);
            for (int i = 0; i < n; i++) begin
                @(negedge bclk);
                data_r[0] = 8'($urandom);
            end
        join
        for (int i = 0; i < n; i++) begin
            e = exp_v.pop_front(); o = obs_v.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL data_change cycle %0d got tx/busy/done=%b exp=%b", i, o, e);
            end
        end
    endtask

    task automatic test_mid_reset;
        int n, bad;
        logic [2:0] e, o;
        valid_r[0] = 1'b1;
        data_r[0]  = 8'h3A;
        @(posedge bclk);
        @(negedge bclk);
        data_r[0] = 8'h81;
        @(negedge bclk);
        @(negedge bclk);
        valid_r[0] = 1'b0;
        checks++;
        if (ready_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_queued got ready=%b exp 0", ready_w[0]);
        end
        repeat (12) @(negedge bclk);
        // Third data bit of 0x3A is 0, so the line is low here.
        checks++;
        if ({tx_w[0], busy_w[0]} !== 2'b01) begin
            failures++;
            $display("FAIL mid_reset_bit2 got tx/busy=%b exp=01", {tx_w[0], busy_w[0]});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_w[0], busy_w[0], done_w[0], ready_w[0]} !== 4'b1001) begin
            failures++;
            $display("FAIL mid_reset_async got tx/busy/done/ready=%b exp=1001",
                     {tx_w[0], busy_w[0], done_w[0], ready_w[0]});
        end
        repeat (3) @(negedge bclk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge bclk);
            if ((tx_w[0] !== 1'b1) || (busy_w[0] !== 1'b0) || (done_w[0] !== 1'b0)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL mid_reset_discard got %0d active cycles exp 0", bad);
        end
        checks++;
        if (ready_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_ready got %b exp 1", ready_w[0]);
        end
        send_word(0, 8'h96);
        checks++;
        if (ready_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_first_edge got ready=%b exp 0", ready_w[0]);
        end
        push_frame(8'h96, 0, 1, 4);
        push_idle(1);
        n = exp_v.size();
        capture(0, n);
        for (int i = 0; i < n; i++) begin
            e = exp_v.pop_front(); o = obs_v.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL mid_reset_next cycle %0d got tx/busy/done=%b exp=%b", i, o, e);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            valid_r[d] = 1'b0;
            data_r[d]  = 8'h00;
        end
        test_reset;
        test_defaults;
        test_parity;
        test_back_to_back;
        test_stop2_fast;
        test_data_change;
        test_mid_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
